// File: rtl/tlul_timeout_guard.sv
`default_nettype none
// ============================================================================
// Module   : tlul_timeout_guard (with its TL-UL type package tlul_pkg)
// Purpose  : TL-UL pass-through that answers stalled requests with an error.
// Revision : 1.0 - initial release
// ============================================================================

package tlul_pkg;

  localparam logic [2:0] c_op_put_full    = 3'd0;
  localparam logic [2:0] c_op_put_partial = 3'd1;
  localparam logic [2:0] c_op_get         = 3'd4;
  localparam logic [2:0] c_rsp_ack        = 3'd0;
  localparam logic [2:0] c_rsp_ack_data   = 3'd1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

module tlul_timeout_guard #(
  parameter int MaxOutstanding = 4,
  parameter int TimeoutCycles  = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  tlul_pkg::tl_h2d_t tl_h_i,
  output tlul_pkg::tl_d2h_t tl_h_o,
  output tlul_pkg::tl_h2d_t tl_d_o,
  input  tlul_pkg::tl_d2h_t tl_d_i,
  output logic              timeout_o,
  output logic              busy_o
);

  localparam int c_ptr_w = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int c_cnt_w = $clog2(MaxOutstanding + 1);
  localparam int c_tmr_w = $clog2(TimeoutCycles);

  localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(MaxOutstanding - 1);
  localparam logic [c_cnt_w:0]   c_limit    = (c_cnt_w + 1)'(MaxOutstanding);
  localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TimeoutCycles - 1);

  typedef enum logic [0:0] {
    ST_NORMAL  = 1'b0,
    ST_ERR_RSP = 1'b1
  } state_e;

  typedef struct packed {
    logic [7:0] source;
    logic [1:0] size;
    logic       is_get;
  } entry_t;

  state_e             r_state;
  state_e             w_state_nxt;
  entry_t             r_mem [MaxOutstanding];
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_cnt_w-1:0] r_count;
  logic [c_cnt_w-1:0] w_count_nxt;
  logic [c_cnt_w-1:0] r_orph;
  logic [c_cnt_w-1:0] w_orph_nxt;
  logic [c_tmr_w-1:0] r_timer;
  logic               r_busy;

  logic               w_empty;
  logic [c_cnt_w:0]   w_inflight;
  logic               w_accept;
  logic               w_push;
  logic               w_sink_mode;
  logic               w_fwd_mode;
  logic               w_fwd_hs;
  logic               w_err_hs;
  logic               w_pop;
  logic               w_sink;
  logic               w_timeout;
  entry_t             w_head;
  entry_t             w_push_ent;

  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_last_ptr) ? '0 : p + c_ptr_w'(1);
  endfunction

  // Outputs are forced quiet for as long as reset is held, not just after an edge.
  assign w_empty     = (r_count == '0);
  assign w_inflight  = {1'b0, r_count} + {1'b0, r_orph};
  assign w_accept    = rst_ni && (r_state == ST_NORMAL) && (w_inflight < c_limit);
  assign w_push      = tl_h_i.a_valid && w_accept && tl_d_i.a_ready;
  assign w_sink_mode = (r_orph != '0);
  assign w_fwd_mode  = rst_ni && (r_state == ST_NORMAL) && !w_sink_mode;
  assign w_fwd_hs    = w_fwd_mode && tl_d_i.d_valid && tl_h_i.d_ready;
  assign w_err_hs    = (r_state == ST_ERR_RSP) && tl_h_i.d_ready;
  assign w_pop       = (w_fwd_hs && !w_empty) || w_err_hs;
  assign w_sink      = rst_ni && w_sink_mode && tl_d_i.d_valid;
  assign w_timeout   = (r_state == ST_NORMAL) && !w_empty &&
                       (r_timer == c_tmr_last) && !w_fwd_hs;
  assign w_head      = r_mem[r_rptr];
  assign w_push_ent  = '{source: tl_h_i.a_source,
                         size:   tl_h_i.a_size,
                         is_get: (tl_h_i.a_opcode == tlul_pkg::c_op_get)};

  always_comb begin
    tl_d_o         = tl_h_i;
    tl_d_o.a_valid = tl_h_i.a_valid && w_accept;
    tl_d_o.d_ready = w_sink_mode || (w_fwd_mode && tl_h_i.d_ready);
    tl_h_o         = '0;
    if (r_state == ST_ERR_RSP) begin
      tl_h_o.d_valid  = 1'b1;
      tl_h_o.d_error  = 1'b1;
      tl_h_o.d_opcode = w_head.is_get ? tlul_pkg::c_rsp_ack_data : tlul_pkg::c_rsp_ack;
      tl_h_o.d_source = w_head.source;
      tl_h_o.d_size   = w_head.size;
      tl_h_o.d_data   = 32'hFFFF_FFFF;
    end else if (w_fwd_mode) begin
      tl_h_o = tl_d_i;
    end
    tl_h_o.a_ready = tl_d_i.a_ready && w_accept;
  end

  assign timeout_o = w_timeout;
  assign busy_o    = r_busy;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_NORMAL:  if (w_timeout) w_state_nxt = ST_ERR_RSP;
      ST_ERR_RSP: if (w_err_hs)  w_state_nxt = ST_NORMAL;
      default:    w_state_nxt = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_NORMAL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + c_cnt_w'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - c_cnt_w'(1);
    end
    w_orph_nxt = r_orph;
    if (w_timeout && !w_sink) begin
      w_orph_nxt = r_orph + c_cnt_w'(1);
    end else if (!w_timeout && w_sink) begin
      w_orph_nxt = r_orph - c_cnt_w'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_push_ent;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_orph  <= '0;
      r_timer <= '0;
      r_busy  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      r_count <= w_count_nxt;
      r_orph  <= w_orph_nxt;
      r_busy  <= (w_count_nxt != '0) || (w_orph_nxt != '0);
      // A fresh head always gets the full window, however long the old one waited.
      if (w_pop || (w_push && w_empty)) begin
        r_timer <= '0;
      end else if (!w_empty && (r_state == ST_NORMAL)) begin
        r_timer <= r_timer + c_tmr_w'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/tlul_timeout_guard.md
TLUL_TIMEOUT_GUARD -- requirements
Module: tlul_timeout_guard

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 4, meaning the maximum number of requests in flight, including orphans; legal range 1..16.
REQ-002 SHALL have parameter TimeoutCycles, default 1024, meaning the cycles allowed for the oldest request to get a response; legal minimum 2.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port tl_h_i, input, tlul_pkg::tl_h2d_t: host request.
REQ-006 SHALL have port tl_h_o, output, tlul_pkg::tl_d2h_t: response to host.
REQ-007 SHALL have port tl_d_o, output, tlul_pkg::tl_h2d_t: request to device.
REQ-008 SHALL have port tl_d_i, input, tlul_pkg::tl_d2h_t: device response.
REQ-009 SHALL have port timeout_o, output, 1 bit: one-cycle pulse on each timeout.
REQ-010 SHALL have port busy_o, output, 1 bit: high when any request or orphan is outstanding.

Function
REQ-011 SHALL forward A-channel fields host->device unchanged.
- tl_d_o.a_valid = tl_h_i.a_valid && accept_en.
- tl_h_o.a_ready = tl_d_i.a_ready && accept_en.
- accept_en = state NORMAL && (pending + orphans < MaxOutstanding).
REQ-012 SHALL, on each A handshake, push {a_source, a_size, is_get} into an in-order tracking FIFO, where is_get = (a_opcode == Get, 4).
REQ-013 SHALL assume the device responds in request order.
REQ-014 SHALL have two states, NORMAL and ERR_RSP.
REQ-015 In NORMAL with orphans==0, SHALL pass D fields device->host unchanged, with tl_d_o.d_ready = tl_h_i.d_ready, and pop the FIFO on the D handshake.
REQ-016 Whenever orphans>0, SHALL sink device D responses: tl_d_o.d_ready=1, nothing forwarded to host, orphans decremented on each, FIFO untouched; this applies in both states.
REQ-017 SHALL run a timer of width $clog2(TimeoutCycles) bits.
- Cleared on reset, on any FIFO pop, and on a push into an empty FIFO.
- Increments while the FIFO is non-empty and state is NORMAL.
- Holds otherwise.
REQ-018 SHALL declare a timeout when the timer == TimeoutCycles-1 and no forwarded D handshake occurs that cycle.
- On timeout: pulse timeout_o, orphans += 1, enter ERR_RSP.
REQ-019 In ERR_RSP, SHALL drive an error response to the host from the FIFO head.
- tl_h_o.d_valid=1, d_error=1.
- d_opcode = AccessAckData(1) if is_get, else AccessAck(0).
- d_source and d_size from the head entry; d_data=32'hFFFF_FFFF.
REQ-020 SHALL block host A requests (accept_en=0) while in ERR_RSP.
REQ-021 SHALL, on the host d_ready handshake in ERR_RSP, pop the FIFO, clear the timer, and return to NORMAL.
REQ-022 A simultaneous A push and FIFO pop SHALL leave the FIFO occupancy unchanged.
REQ-023 A simultaneous timeout increment and sunk orphan response SHALL leave the orphan count unchanged.
REQ-024 A device response that coincides with the timeout threshold SHALL win: it is forwarded, the FIFO pops, and no timeout occurs.
REQ-025 busy_o SHALL equal (FIFO non-empty || orphans>0), registered.

Reset
REQ-026 On rst_ni low, asynchronously:
- state=NORMAL, FIFO empty, timer=0, orphans=0.
- timeout_o=0, busy_o=0.
- tl_h_o.d_valid=0, tl_d_o.a_valid=0.
REQ-027 Reset mid-transaction SHALL discard all tracking state; no error response is generated after reset release.

Verification
REQ-028 Bench uses TimeoutCycles=16, MaxOutstanding=2 for all scenarios below.
REQ-029 Put 0xDEADBEEF to 0x4000_0000, device answers after 3 cycles -> host gets AccessAck with d_error=0; timeout_o stays 0; busy_o falls after the response.
REQ-030 Get to 0x5000_0000 with a silent device -> timeout_o pulses exactly 16 cycles after acceptance; host gets AccessAckData with d_error=1 and data 0xFFFFFFFF, same source.
REQ-031 After REQ-030, device sends a late response, then a new Get is answered normally -> late response sunk; host sees exactly one response, with d_error=0.
REQ-032 Three back-to-back Puts with a stalled device -> third a_ready=0 until the first D handshake.
REQ-033 Device d_valid arrives in the exact threshold cycle -> response forwarded, no timeout_o pulse.
REQ-034 rst_ni asserted during ERR_RSP -> all outputs at reset values; no d_valid to host after release.
